// File: rtl/branch_pkg.sv
// Shared constants for the branch prediction unit: instruction opcode and
// func3 codes, FSM state encoding and the history-counter reset value.
package branch_pkg;

   localparam logic [4:0] OP_BRANCH   = 5'b11000;
   localparam logic [4:0] OP_JAL      = 5'b11011;
   localparam logic [4:0] OP_JALR     = 5'b11001;
   localparam logic [4:0] OP_SYSTEM   = 5'b11100;
   localparam logic [4:0] OP_MISC_MEM = 5'b00011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   // Weakly not-taken: 2^(cnt_w-1)-1 for a counter cnt_w bits wide.
   function automatic int unsigned cnt_init(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/branch_history_table.sv
// Array of saturating direction counters.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (all entries -> weakly not-taken)
//   rd_idx / rd_cnt  combinational lookup; returns the pre-update value on a same-index write
//   wr_en, wr_idx,   read-modify-write port: increment (wr_taken=1) or decrement,
//   wr_taken         saturating at both ends
module branch_history_table
   import branch_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int CNT_W = 2,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [CNT_W-1:0] rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_MIN  = '0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_init(CNT_W));

   logic [CNT_W-1:0] table_q [DEPTH];
   logic [CNT_W-1:0] table_d [DEPTH];
   logic [CNT_W-1:0] wr_cur;

   assign rd_cnt = table_q[rd_idx];

   always_comb begin
      table_d = table_q;
      wr_cur  = table_q[wr_idx];
      if (wr_en) begin
         if (wr_taken && (wr_cur != CNT_MAX)) begin
            table_d[wr_idx] = wr_cur + 1'b1;
         end else if (!wr_taken && (wr_cur != CNT_MIN)) begin
            table_d[wr_idx] = wr_cur - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= CNT_INIT;
         end
      end else begin
         table_q <= table_d;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution unit.
// Fetch side: pred_taken is the MSB of the history counter indexed by f_pc.
// Execute side: resolves conditional branches from ALU flags, flags
// mispredicts, trains the history table, counts branches/mispredicts and
// handles SYSTEM (one-cycle ebranch) and MISC-MEM (halt until resume).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   f_pc -> pred_taken              fetch lookup
//   ex_valid, ex_inst, ex_pc,       execute-stage instruction and the prediction
//   ex_pred, zf/cf/vf/sf            it carried, plus ALU flags
//   resume                          release from HALTED
//   branch, mispredict, ebranch,    resolution outputs (combinational)
//   repeat_branch
//   br_count, mp_count              saturating statistics
//
// state   | meaning
// RUN     | normal operation, table and statistics train
// HALTED  | after MISC-MEM; ebranch/repeat_branch held high, no updates
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] f_pc,
   output logic            pred_taken,
   input  logic            ex_valid,
   input  logic [31:0]     ex_inst,
   input  logic [PC_W-1:0] ex_pc,
   input  logic            ex_pred,
   input  logic            zf,
   input  logic            cf,
   input  logic            vf,
   input  logic            sf,
   input  logic            resume,
   output logic            branch,
   output logic            mispredict,
   output logic            ebranch,
   output logic            repeat_branch,
   output logic [15:0]     br_count,
   output logic [15:0]     mp_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [4:0]       opcode;
   logic [2:0]       func3;
   logic             is_cond;
   logic             cond_taken;
   logic             in_run;
   logic             upd_en;
   logic [CNT_W-1:0] lookup_cnt;
   logic [0:0]       state_q, state_d;
   logic [15:0]      br_count_q, br_count_d;
   logic [15:0]      mp_count_q, mp_count_d;
   logic             unused_bits;

   assign opcode  = ex_inst[6:2];
   assign func3   = ex_inst[14:12];
   assign is_cond = (opcode == OP_BRANCH);
   assign in_run  = (state_q == ST_RUN);

   assign unused_bits = ^{ex_inst[31:15], ex_inst[11:7], ex_inst[1:0],
                          f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                          ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

   always_comb begin
      cond_taken = 1'b0;
      case (func3)
         F3_BEQ:  cond_taken = zf;
         F3_BNE:  cond_taken = !zf;
         F3_BLT:  cond_taken = (sf != vf);
         F3_BGE:  cond_taken = (sf == vf);
         F3_BLTU: cond_taken = !cf;
         F3_BGEU: cond_taken = cf;
         default: cond_taken = 1'b0;
      endcase
   end

   always_comb begin
      branch = 1'b0;
      if (ex_valid) begin
         if (is_cond) begin
            branch = cond_taken;
         end else if ((opcode == OP_JAL) || (opcode == OP_JALR)) begin
            branch = 1'b1;
         end
      end
   end

   assign mispredict = ex_valid && is_cond && (branch != ex_pred);

   always_comb begin
      ebranch       = 1'b0;
      repeat_branch = 1'b0;
      state_d       = state_q;
      if (!in_run) begin
         ebranch       = 1'b1;
         repeat_branch = 1'b1;
         if (resume) begin
            state_d = ST_RUN;
         end
      end else if (ex_valid) begin
         if (opcode == OP_SYSTEM) begin
            ebranch = 1'b1;
         end else if (opcode == OP_MISC_MEM) begin
            ebranch       = 1'b1;
            repeat_branch = 1'b1;
            state_d       = ST_HALTED;
         end
      end
   end

   assign upd_en = in_run && ex_valid && is_cond;

   always_comb begin
      br_count_d = br_count_q;
      mp_count_d = mp_count_q;
      if (upd_en && (br_count_q != 16'hFFFF)) begin
         br_count_d = br_count_q + 16'd1;
      end
      if (in_run && mispredict && (mp_count_q != 16'hFFFF)) begin
         mp_count_d = mp_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         br_count_q <= 16'd0;
         mp_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         br_count_q <= br_count_d;
         mp_count_q <= mp_count_d;
      end
   end

   branch_history_table #(
      .DEPTH (BHT_DEPTH),
      .CNT_W (CNT_W)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (f_pc[IDX_W+1:2]),
      .rd_cnt   (lookup_cnt),
      .wr_en    (upd_en),
      .wr_idx   (ex_pc[IDX_W+1:2]),
      .wr_taken (branch)
   );

   assign pred_taken = lookup_cnt[CNT_W-1];
   assign br_count   = br_count_q;
   assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] f_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic [31:0] ex_inst;
   logic [31:0] ex_pc;
   logic        ex_pred;
   logic        zf, cf, vf, sf;
   logic        resume;
   logic        branch, mispredict, ebranch, repeat_branch;
   logic [15:0] br_count, mp_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predict_unit #(
      .PC_W      (32),
      .BHT_DEPTH (64),
      .CNT_W     (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .f_pc          (f_pc),
      .pred_taken    (pred_taken),
      .ex_valid      (ex_valid),
      .ex_inst       (ex_inst),
      .ex_pc         (ex_pc),
      .ex_pred       (ex_pred),
      .zf            (zf),
      .cf            (cf),
      .vf            (vf),
      .sf            (sf),
      .resume        (resume),
      .branch        (branch),
      .mispredict    (mispredict),
      .ebranch       (ebranch),
      .repeat_branch (repeat_branch),
      .br_count      (br_count),
      .mp_count      (mp_count)
   );

   function automatic logic [31:0] mk_inst(input logic [4:0] op, input logic [2:0] f3);
      return {17'd0, f3, 5'd0, op, 2'b11};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic pred);
      ex_valid = v;
      ex_inst  = mk_inst(op, f3);
      ex_pc    = pc;
      ex_pred  = pred;
   endtask

   initial begin
      rst_n = 1'b0; f_pc = 32'h40; resume = 1'b0;
      zf = 1'b0; cf = 1'b0; vf = 1'b0; sf = 1'b0;
      set_ex(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_pred", {31'd0, pred_taken}, 32'd0);
      chk("rst_br", {16'd0, br_count}, 32'd0);
      chk("rst_mp", {16'd0, mp_count}, 32'd0);
      chk("rst_ebr", {31'd0, ebranch}, 32'd0);
      chk("rst_rep", {31'd0, repeat_branch}, 32'd0);

      // Three taken BEQ at 0x40, predicted not-taken: counter 1->2->3->3
      zf = 1'b1;
      set_ex(1'b1, 5'b11000, 3'b000, 32'h40, 1'b0);
      #1;
      chk("beq1_branch", {31'd0, branch}, 32'd1);
      chk("beq1_mp", {31'd0, mispredict}, 32'd1);
      tick();
      chk("beq1_mpcnt", {16'd0, mp_count}, 32'd1);
      chk("beq1_brcnt", {16'd0, br_count}, 32'd1);
      tick();
      chk("beq2_pred", {31'd0, pred_taken}, 32'd1);
      tick();
      chk("beq3_pred", {31'd0, pred_taken}, 32'd1);
      chk("beq3_brcnt", {16'd0, br_count}, 32'd3);
      chk("beq3_mpcnt", {16'd0, mp_count}, 32'd3);

      // Two not-taken BEQ: 3->2 (still taken) ->1 (not taken) proves saturation at 3
      zf = 1'b0;
      set_ex(1'b1, 5'b11000, 3'b000, 32'h40, 1'b1);
      #1;
      chk("nt1_mp", {31'd0, mispredict}, 32'd1);
      tick();
      chk("nt1_pred", {31'd0, pred_taken}, 32'd1);
      ex_pred = 1'b0;
      #1;
      chk("nt2_mp", {31'd0, mispredict}, 32'd0);
      tick();
      chk("nt2_pred", {31'd0, pred_taken}, 32'd0);
      chk("nt2_brcnt", {16'd0, br_count}, 32'd5);
      chk("nt2_mpcnt", {16'd0, mp_count}, 32'd4);

      // Conditions on other func3 codes at 0xC0
      cf = 1'b0;
      set_ex(1'b1, 5'b11000, 3'b110, 32'hC0, 1'b1);
      #1;
      chk("bltu_branch", {31'd0, branch}, 32'd1);
      chk("bltu_mp", {31'd0, mispredict}, 32'd0);
      tick();
      set_ex(1'b1, 5'b11000, 3'b111, 32'hC0, 1'b0);
      #1;
      chk("bgeu_branch", {31'd0, branch}, 32'd0);
      tick();
      zf = 1'b1;
      set_ex(1'b1, 5'b11000, 3'b010, 32'hC0, 1'b0);
      #1;
      chk("f3_010_branch", {31'd0, branch}, 32'd0);
      tick();
      zf = 1'b0; sf = 1'b1; vf = 1'b0;
      set_ex(1'b1, 5'b11000, 3'b100, 32'hC0, 1'b1);
      #1;
      chk("blt_branch", {31'd0, branch}, 32'd1);
      tick();
      sf = 1'b0;
      chk("cond_brcnt", {16'd0, br_count}, 32'd9);
      chk("cond_mpcnt", {16'd0, mp_count}, 32'd4);

      // JAL: taken redirect, no training, no count
      set_ex(1'b1, 5'b11011, 3'b000, 32'h40, 1'b0);
      #1;
      chk("jal_branch", {31'd0, branch}, 32'd1);
      chk("jal_mp", {31'd0, mispredict}, 32'd0);
      tick();
      chk("jal_pred", {31'd0, pred_taken}, 32'd0);
      chk("jal_brcnt", {16'd0, br_count}, 32'd9);
      ex_valid = 1'b0;
      #1;
      chk("jal_invalid", {31'd0, branch}, 32'd0);

      // Same-cycle lookup and update at 0x80: counter 1->2
      f_pc = 32'h80; zf = 1'b1;
      set_ex(1'b1, 5'b11000, 3'b000, 32'h80, 1'b0);
      #1;
      chk("same_pred_before", {31'd0, pred_taken}, 32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("same_pred_after", {31'd0, pred_taken}, 32'd1);
      chk("same_brcnt", {16'd0, br_count}, 32'd10);
      chk("same_mpcnt", {16'd0, mp_count}, 32'd5);

      // SYSTEM: ebranch for one cycle only
      set_ex(1'b1, 5'b11100, 3'b000, 32'h100, 1'b0);
      #1;
      chk("sys_ebr", {31'd0, ebranch}, 32'd1);
      chk("sys_rep", {31'd0, repeat_branch}, 32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      chk("sys_ebr_next", {31'd0, ebranch}, 32'd0);

      // MISC-MEM: halt; five BEQ must not train or count
      set_ex(1'b1, 5'b00011, 3'b000, 32'h104, 1'b0);
      #1;
      chk("mm_ebr", {31'd0, ebranch}, 32'd1);
      chk("mm_rep", {31'd0, repeat_branch}, 32'd1);
      tick();
      f_pc = 32'h40; zf = 1'b1;
      set_ex(1'b1, 5'b11000, 3'b000, 32'h40, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("halt_ebr", {31'd0, ebranch}, 32'd1);
         chk("halt_rep", {31'd0, repeat_branch}, 32'd1);
         tick();
      end
      ex_valid = 1'b0;
      #1;
      chk("halt_brcnt", {16'd0, br_count}, 32'd10);
      chk("halt_mpcnt", {16'd0, mp_count}, 32'd5);
      chk("halt_pred", {31'd0, pred_taken}, 32'd0);

      resume = 1'b1;
      #1;
      chk("resume_ebr_now", {31'd0, ebranch}, 32'd1);
      tick();
      resume = 1'b0;
      #1;
      chk("resume_ebr", {31'd0, ebranch}, 32'd0);
      chk("resume_rep", {31'd0, repeat_branch}, 32'd0);

      resume = 1'b1;
      tick();
      resume = 1'b0;
      #1;
      chk("resume_run_ebr", {31'd0, ebranch}, 32'd0);

      // Reset while HALTED overrides resume and a pending BEQ
      set_ex(1'b1, 5'b00011, 3'b000, 32'h108, 1'b0);
      tick();
      rst_n = 1'b0; resume = 1'b1;
      set_ex(1'b1, 5'b11000, 3'b000, 32'h80, 1'b0);
      #1;
      chk("rsth_ebr_before", {31'd0, ebranch}, 32'd1);
      tick();
      rst_n = 1'b1; resume = 1'b0; ex_valid = 1'b0; f_pc = 32'h80;
      #1;
      chk("rsth_ebr", {31'd0, ebranch}, 32'd0);
      chk("rsth_rep", {31'd0, repeat_branch}, 32'd0);
      chk("rsth_brcnt", {16'd0, br_count}, 32'd0);
      chk("rsth_mpcnt", {16'd0, mp_count}, 32'd0);
      chk("rsth_pred", {31'd0, pred_taken}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
